// File: rtl/gate_recv.sv
// gate_recv: receive-side gateway that checks inbound remote read/write requests
// against per-endpoint address windows and access rights before they reach local DMA.
//   Latency: 2 cycles from acceptance to m_req_valid. Backpressure: m_req_ready stalls S2,
//   then S1, then s_req_ready. Requests that fail the check free S1 even while S2 is stalled.
// Ports:
//   aclk, aresetn        clock and asynchronous active-low reset
//   mem_ctrl             99 bits per endpoint: [47:0] base, [95:48] inclusive bound,
//                        [97:96] rights (bit0 read, bit1 write), [98] valid
//   s_req_*              inbound request (valid/ready handshake)
//   m_req_*              authorized request plus index of the matching endpoint
//   viol_pulse/count     one-cycle pulse and saturating count of dropped requests
// Optional macro GATE_RECV_VIOL_LOG_EN adds viol_clr and viol_log_* (first-violation log).
module gate_recv #(
  parameter int N_ENDPOINTS = 4,
  parameter int VADDR_W     = 48,
  parameter int LEN_W       = 28,
  localparam int EP_W       = (N_ENDPOINTS > 1) ? $clog2(N_ENDPOINTS) : 1
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [99*N_ENDPOINTS-1:0]  mem_ctrl,
  input  logic                       s_req_valid,
  output logic                       s_req_ready,
  input  logic [VADDR_W-1:0]         s_req_vaddr,
  input  logic [LEN_W-1:0]           s_req_len,
  input  logic                       s_req_wr,
  output logic                       m_req_valid,
  input  logic                       m_req_ready,
  output logic [VADDR_W-1:0]         m_req_vaddr,
  output logic [LEN_W-1:0]           m_req_len,
  output logic                       m_req_wr,
  output logic [EP_W-1:0]            m_req_ep,
`ifdef GATE_RECV_VIOL_LOG_EN
  input  logic                       viol_clr,
  output logic                       viol_log_valid,
  output logic [VADDR_W-1:0]         viol_log_vaddr,
  output logic                       viol_log_wr,
`endif
  output logic                       viol_pulse,
  output logic [31:0]                viol_count
);

  localparam int XW = VADDR_W + 1;

  // Endpoint table, registered copy of mem_ctrl.
  logic [N_ENDPOINTS-1:0][VADDR_W-1:0] tbl_base_q, tbl_base_d;
  logic [N_ENDPOINTS-1:0][VADDR_W-1:0] tbl_bound_q, tbl_bound_d;
  logic [N_ENDPOINTS-1:0][1:0]         tbl_rights_q, tbl_rights_d;
  logic [N_ENDPOINTS-1:0]              tbl_vld_q, tbl_vld_d;

  // Holds s_req_ready low until the first clock edge after reset release.
  logic rdy_en_q, rdy_en_d;

  logic               s1_valid_q, s1_valid_d;
  logic [VADDR_W-1:0] s1_vaddr_q, s1_vaddr_d;
  logic [LEN_W-1:0]   s1_len_q, s1_len_d;
  logic               s1_wr_q, s1_wr_d;

  logic               s2_valid_q, s2_valid_d;
  logic [VADDR_W-1:0] s2_vaddr_q, s2_vaddr_d;
  logic [LEN_W-1:0]   s2_len_q, s2_len_d;
  logic               s2_wr_q, s2_wr_d;
  logic [EP_W-1:0]    s2_ep_q, s2_ep_d;

  logic               viol_pulse_q, viol_pulse_d;
  logic [31:0]        viol_count_q, viol_count_d;

  logic [N_ENDPOINTS-1:0] ep_match;
  logic                   s1_allowed;
  logic [EP_W-1:0]        s1_ep;
  logic                   s1_adv;
  logic                   s_acc;
  logic                   viol_now;

  // An entry whose base exceeds its bound is folded into the valid bit here,
  // so the decision logic only has to look at tbl_vld_q.
  always_comb begin
    tbl_base_d   = tbl_base_q;
    tbl_bound_d  = tbl_bound_q;
    tbl_rights_d = tbl_rights_q;
    tbl_vld_d    = tbl_vld_q;
    for (int i = 0; i < N_ENDPOINTS; i++) begin
      tbl_base_d[i]   = VADDR_W'(mem_ctrl[99*i +: 48]);
      tbl_bound_d[i]  = VADDR_W'(mem_ctrl[99*i+48 +: 48]);
      tbl_rights_d[i] = mem_ctrl[99*i+96 +: 2];
      tbl_vld_d[i]    = mem_ctrl[99*i+98] && (tbl_base_d[i] <= tbl_bound_d[i]);
    end
  end

  // Window checks are done one bit wider than the address so that a window
  // ending at the top of the address space cannot wrap.
  logic [XW-1:0] len_ext;
  logic [XW-1:0] vaddr_ext;
  assign len_ext   = XW'(s1_len_q);
  assign vaddr_ext = {1'b0, s1_vaddr_q};

  for (genvar g = 0; g < N_ENDPOINTS; g++) begin : g_ep
    logic [XW-1:0] size_w;
    logic [XW-1:0] last_start;
    assign size_w     = {1'b0, tbl_bound_q[g]} - {1'b0, tbl_base_q[g]} + XW'(1);
    assign last_start = {1'b0, tbl_bound_q[g]} + XW'(1) - len_ext;
    assign ep_match[g] = tbl_vld_q[g]
                      && tbl_rights_q[g][s1_wr_q]
                      && (len_ext != '0)
                      && (len_ext <= size_w)
                      && (vaddr_ext >= {1'b0, tbl_base_q[g]})
                      && (vaddr_ext <= last_start);
  end

  // Lowest matching index wins: scan high to low so the lowest overwrites last.
  always_comb begin
    s1_allowed = 1'b0;
    s1_ep      = '0;
    for (int i = N_ENDPOINTS - 1; i >= 0; i--) begin
      if (ep_match[i]) begin
        s1_allowed = 1'b1;
        s1_ep      = EP_W'(i);
      end
    end
  end

  assign s1_adv      = s1_valid_q && (!s1_allowed || !s2_valid_q || m_req_ready);
  assign s_req_ready = rdy_en_q && (!s1_valid_q || s1_adv);
  assign s_acc       = s_req_valid && s_req_ready;
  assign viol_now    = s1_adv && !s1_allowed;

  always_comb begin
    rdy_en_d   = 1'b1;

    s1_valid_d = s1_valid_q;
    s1_vaddr_d = s1_vaddr_q;
    s1_len_d   = s1_len_q;
    s1_wr_d    = s1_wr_q;
    if (s_acc) begin
      s1_valid_d = 1'b1;
      s1_vaddr_d = s_req_vaddr;
      s1_len_d   = s_req_len;
      s1_wr_d    = s_req_wr;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    // A load in the same cycle as a drain replaces the departing entry.
    s2_valid_d = s2_valid_q;
    s2_vaddr_d = s2_vaddr_q;
    s2_len_d   = s2_len_q;
    s2_wr_d    = s2_wr_q;
    s2_ep_d    = s2_ep_q;
    if (s1_adv && s1_allowed) begin
      s2_valid_d = 1'b1;
      s2_vaddr_d = s1_vaddr_q;
      s2_len_d   = s1_len_q;
      s2_wr_d    = s1_wr_q;
      s2_ep_d    = s1_ep;
    end else if (m_req_ready) begin
      s2_valid_d = 1'b0;
    end

    viol_pulse_d = viol_now;
    viol_count_d = viol_count_q;
    if (viol_now && (viol_count_q != 32'hFFFF_FFFF)) begin
      viol_count_d = viol_count_q + 32'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tbl_base_q   <= '0;
      tbl_bound_q  <= '0;
      tbl_rights_q <= '0;
      tbl_vld_q    <= '0;
      rdy_en_q     <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_vaddr_q   <= '0;
      s1_len_q     <= '0;
      s1_wr_q      <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_vaddr_q   <= '0;
      s2_len_q     <= '0;
      s2_wr_q      <= 1'b0;
      s2_ep_q      <= '0;
      viol_pulse_q <= 1'b0;
      viol_count_q <= '0;
    end else begin
      tbl_base_q   <= tbl_base_d;
      tbl_bound_q  <= tbl_bound_d;
      tbl_rights_q <= tbl_rights_d;
      tbl_vld_q    <= tbl_vld_d;
      rdy_en_q     <= rdy_en_d;
      s1_valid_q   <= s1_valid_d;
      s1_vaddr_q   <= s1_vaddr_d;
      s1_len_q     <= s1_len_d;
      s1_wr_q      <= s1_wr_d;
      s2_valid_q   <= s2_valid_d;
      s2_vaddr_q   <= s2_vaddr_d;
      s2_len_q     <= s2_len_d;
      s2_wr_q      <= s2_wr_d;
      s2_ep_q      <= s2_ep_d;
      viol_pulse_q <= viol_pulse_d;
      viol_count_q <= viol_count_d;
    end
  end

  assign m_req_valid = s2_valid_q;
  assign m_req_vaddr = s2_vaddr_q;
  assign m_req_len   = s2_len_q;
  assign m_req_wr    = s2_wr_q;
  assign m_req_ep    = s2_ep_q;
  assign viol_pulse  = viol_pulse_q;
  assign viol_count  = viol_count_q;

`ifdef GATE_RECV_VIOL_LOG_EN
  logic               log_vld_q, log_vld_d;
  logic [VADDR_W-1:0] log_vaddr_q, log_vaddr_d;
  logic               log_wr_q, log_wr_d;

  // A violation in the same cycle as a clear wins, so it is never lost.
  always_comb begin
    log_vld_d   = log_vld_q;
    log_vaddr_d = log_vaddr_q;
    log_wr_d    = log_wr_q;
    if (viol_now && (!log_vld_q || viol_clr)) begin
      log_vld_d   = 1'b1;
      log_vaddr_d = s1_vaddr_q;
      log_wr_d    = s1_wr_q;
    end else if (viol_clr) begin
      log_vld_d   = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      log_vld_q   <= 1'b0;
      log_vaddr_q <= '0;
      log_wr_q    <= 1'b0;
    end else begin
      log_vld_q   <= log_vld_d;
      log_vaddr_q <= log_vaddr_d;
      log_wr_q    <= log_wr_d;
    end
  end

  assign viol_log_valid = log_vld_q;
  assign viol_log_vaddr = log_vaddr_q;
  assign viol_log_wr    = log_wr_q;
`endif

endmodule

// File: doc/gate_recv.md
Name: gate_recv

Overview:
- Receive-side gateway: validates inbound remote memory requests (RDMA/network-originated reads and writes targeting local memory) against per-endpoint bounds and access rights before they reach the local DMA engine.
- Counterpart of the send-side gateway; uses the same 99-bit-per-endpoint mem_ctrl encoding.
- Registered 2-stage pipeline with backpressure; unauthorized requests are dropped, then counted and flagged.

Parameters:
- N_ENDPOINTS, 4, number of endpoint windows in mem_ctrl.
- VADDR_W, 48, virtual address width.
- LEN_W, 28, request length width in bytes.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- mem_ctrl  in  99*N_ENDPOINTS  per endpoint i at offset 99*i: [47:0] base, [95:48] bound (inclusive), [97:96] rights (bit0 read, bit1 write), [98] valid.
- s_req_valid  in  1  inbound request valid.
- s_req_ready  out  1  inbound request accepted.
- s_req_vaddr  in  VADDR_W  request start address.
- s_req_len  in  LEN_W  request length, bytes.
- s_req_wr  in  1  0 = read, 1 = write.
- m_req_valid  out  1  authorized request valid.
- m_req_ready  in  1  downstream ready.
- m_req_vaddr  out  VADDR_W  forwarded address.
- m_req_len  out  LEN_W  forwarded length.
- m_req_wr  out  1  forwarded opcode.
- m_req_ep  out  $clog2(N_ENDPOINTS) (min 1)  index of the matching endpoint.
- viol_pulse  out  1  one-cycle pulse per dropped request.
- viol_count  out  32  saturating count of dropped requests.
- (macro only) viol_clr  in  1; viol_log_valid  out  1; viol_log_vaddr  out  VADDR_W; viol_log_wr  out  1.

Behaviour:
- Reset values: s_req_ready 0, m_req_valid 0, m_req_* 0, viol_pulse 0, viol_count 0, endpoint table all invalid.
- Endpoint table: registered from mem_ctrl every cycle (1-cycle lag).
  - An entry with base > bound is treated as invalid.
  - Decisions use the table value in the cycle the decision is made.
- Stage S1 (input register): captures s_req_* on s_req_valid && s_req_ready.
  - s_req_ready = !s1_valid || s1_adv.
  - s1_adv = s1_valid && (!s1_allowed || !s2_valid || m_req_ready).
  - s_req_ready is 0 during reset.
- Decision on S1 contents: allowed iff len != 0 and there exists a valid endpoint i with rights[s1_wr] = 1, and:
  - size = bound - base + 1, computed VADDR_W+1 wide (no wrap);
  - len <= size;
  - vaddr >= base;
  - vaddr <= bound - len + 1, computed VADDR_W+1 wide.
  - Lowest matching index wins and is reported on m_req_ep.
- Stage S2 (output register): loads on s1_adv && s1_allowed.
  - m_req_* hold stable while m_req_valid && !m_req_ready.
  - Latency: 2 cycles from acceptance to m_req_valid with no backpressure.
  - Throughput: 1 request/cycle.
- Unauthorized: on s1_adv && !s1_allowed, the request is discarded (S1 frees even if S2 is stalled).
  - viol_pulse = 1 the next cycle.
  - viol_count += 1, saturating at 0xFFFFFFFF.
- Simultaneous S2 drain and load in the same cycle: the new request replaces the old one; no bubble.
- Reset mid-transfer: the asynchronous assert clears both stages immediately; in-flight requests are lost and not counted.

Optional Feature:
- Macro GATE_RECV_VIOL_LOG_EN.
- Defined:
  - The first dropped request's vaddr and wr are captured into viol_log_vaddr/viol_log_wr and viol_log_valid is set.
  - Later violations do not overwrite the log while viol_log_valid = 1.
  - viol_clr clears viol_log_valid; if clr and a new violation occur in the same cycle, the new violation is captured.
- Not defined: the log ports and logic are absent; all other behaviour is identical.

Test Plan:
- EP0 base 0x1000, bound 0x1FFF, rights 2'b11, valid; write vaddr 0x1F00 len 0x100 -> m_req_valid 2 cycles after accept, m_req_ep = 0, viol_count 0.
- Same EP0; read vaddr 0x1F01 len 0x100 -> dropped, viol_pulse once, viol_count 1, m_req_valid stays 0.
- EP0 rights 2'b01; write vaddr 0x1000 len 4 -> dropped. EP1 base 0x1000, bound 0x1FFF, rights 2'b10 -> the same write is forwarded with m_req_ep = 1.
- EP0 base 0xFFFF_FFFF_F000, bound 0xFFFF_FFFF_FFFF; len 0x2000 at vaddr 0xFFFF_FFFF_F000 -> dropped (len > size, no wrap); len 0x1000 -> forwarded; len 0 -> dropped.
- Hold m_req_ready = 0 and stream 3 valid requests -> 2 captured (S2 + S1), s_req_ready = 0, outputs stable; release ready -> all 3 emerge in order, no loss or duplication.
- With GATE_RECV_VIOL_LOG_EN: violations at 0x5000 then 0x6000 -> log holds 0x5000; pulse viol_clr; violation at 0x7000 -> log holds 0x7000.
